// File: rtl/mem_in_pkg.sv
// Shared types and constants for the memory-mapped input slice.
package mem_in_pkg;

    // Default bus geometry
    localparam int unsigned DEF_AW = 15;
    localparam int unsigned DEF_DW = 16;

    // Register offsets from the slice base address
    localparam int unsigned LEVEL_OFS = 0;
    localparam int unsigned EDGE_OFS  = 1;

    // Which accepted level transitions set the sticky edge register
    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_BOTH = 2'd2
    } edge_mode_t;

endpackage : mem_in_pkg

// File: rtl/in_debounce.sv
// Single-bit debouncer: accepts a new level only after DEB_CYCLES
// consecutive cycles of disagreement with the current level.
module in_debounce #(
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic clk50m,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic chg
);

    localparam int unsigned CW      = $clog2(DEB_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic          q_q;
    logic          q_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count disagreeing cycles; take the new level when the run is long enough
    always_comb begin
        q_d   = q_q;
        cnt_d = '0;
        chg   = 1'b0;
        if (d != q_q) begin
            if (cnt_q == CNT_MAX) begin
                q_d = d;
                chg = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Level and run-length registers
    always_ff @(posedge clk50m) begin
        if (rst) begin
            q_q   <= 1'b0;
            cnt_q <= '0;
        end else begin
            q_q   <= q_d;
            cnt_q <= cnt_d;
        end
    end

    assign q = q_q;

endmodule : in_debounce

// File: rtl/mem_in_slice.sv
// Memory-mapped input port: synchronized (optionally debounced) pin level
// at ADDRESS and a sticky, read-to-clear edge register at ADDRESS+1.
// Build option: define MEM_IN_DEBOUNCE_EN to insert per-bit debouncers;
// otherwise the level register follows the synchronizer every cycle.
module mem_in_slice
    import mem_in_pkg::*;
#(
    parameter int unsigned   AW         = DEF_AW,
    parameter int unsigned   DW         = DEF_DW,
    parameter logic [AW-1:0] ADDRESS    = 15'h7100,
    parameter edge_mode_t    EDGE_MODE  = EDGE_RISE,
    parameter int unsigned   DEB_CYCLES = 4
) (
    input  logic          clk50m,
    input  logic          rst,
    input  logic [AW-1:0] addr,
    input  logic          re,
    input  logic [DW-1:0] pins_i,
    output logic [DW-1:0] data_out,
    output logic          hit,
    output logic          irq
);

    localparam logic [AW-1:0] LEVEL_ADDR = ADDRESS + AW'(LEVEL_OFS);
    localparam logic [AW-1:0] EDGE_ADDR  = ADDRESS + AW'(EDGE_OFS);

    // A zero debounce length is meaningless; leave a visible marker in the hierarchy
    if (DEB_CYCLES < 1) begin : g_deb_cycles_invalid
    end

    logic [DW-1:0] sync1_q;
    logic [DW-1:0] sync1_d;
    logic [DW-1:0] sync2_q;
    logic [DW-1:0] sync2_d;
    logic [DW-1:0] edge_q;
    logic [DW-1:0] edge_d;
    logic          irq_q;
    logic          irq_d;

    logic [DW-1:0] level;   // accepted pin level
    logic [DW-1:0] upd;     // per-bit pulse in the cycle the level is replaced
    logic [DW-1:0] change;  // update pulses qualified by the edge mode
    logic          clr;

    // Two-flop synchronizer, no logic between the stages
    always_comb begin
        sync1_d = pins_i;
        sync2_d = sync1_q;
    end

    // Synchronizer registers
    always_ff @(posedge clk50m) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

`ifdef MEM_IN_DEBOUNCE_EN
    // One debouncer per pin
    for (genvar i = 0; i < int'(DW); i++) begin : g_deb
        in_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk50m (clk50m),
            .rst    (rst),
            .d      (sync2_q[i]),
            .q      (level[i]),
            .chg    (upd[i])
        );
    end
`else
    logic [DW-1:0] level_q;
    logic [DW-1:0] level_d;

    // Without debouncing the level simply tracks the synchronizer output
    always_comb begin
        level_d = sync2_q;
        upd     = sync2_q ^ level_q;
    end

    // Level register
    always_ff @(posedge clk50m) begin
        if (rst) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign level = level_q;
`endif

    // Qualify updates by direction; the new level equals sync2 in an update cycle
    always_comb begin
        change = '0;
        case (EDGE_MODE)
            EDGE_RISE: change = upd & sync2_q;
            EDGE_FALL: change = upd & ~sync2_q;
            default:   change = upd;
        endcase
    end

    // Sticky edges with read-to-clear; a same-cycle new edge survives the clear
    always_comb begin
        clr    = re && (addr == EDGE_ADDR);
        edge_d = (edge_q & ~{DW{clr}}) | change;
        irq_d  = |edge_d;
    end

    // Edge and interrupt registers
    always_ff @(posedge clk50m) begin
        if (rst) begin
            edge_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            edge_q <= edge_d;
            irq_q  <= irq_d;
        end
    end

    // Read decode, combinational from the registers
    always_comb begin
        data_out = '0;
        hit      = 1'b0;
        if (addr == LEVEL_ADDR) begin
            data_out = level;
            hit      = 1'b1;
        end else if (addr == EDGE_ADDR) begin
            data_out = edge_q;
            hit      = 1'b1;
        end
    end

    assign irq = irq_q;

endmodule : mem_in_slice

// File: tb/tb_mem_in_slice.sv
// Self-checking bench for mem_in_slice: three instances (rise, fall, both)
// share stimulus and are compared against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_mem_in_slice;
    import mem_in_pkg::*;

    localparam int unsigned   AW     = 15;
    localparam int unsigned   DW     = 16;
    localparam logic [14:0]   BASE   = 15'h7100;
    localparam logic [14:0]   EDGE_A = 15'h7101;
    localparam logic [14:0]   NONE_A = 15'h7102;
    localparam int            DEB    = 4;
`ifdef MEM_IN_DEBOUNCE_EN
    localparam int            DEB_M  = DEB;
`else
    localparam int            DEB_M  = 1;
`endif
    localparam int            DL     = 2 + DEB_M;

    logic          clk50m = 1'b0;
    logic          rst;
    logic [14:0]   addr;
    logic          re;
    logic [15:0]   pins_i;
    logic [15:0]   dout [3];
    logic [2:0]    hit_v;
    logic [2:0]    irq_v;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    logic [15:0] m_s1, m_s2, m_lvl;
    logic [15:0] m_edg [3];
    logic [2:0]  m_irq;
    int          m_run [16];

    always #5 clk50m = ~clk50m;

    mem_in_slice #(.AW(AW), .DW(DW), .ADDRESS(BASE), .EDGE_MODE(EDGE_RISE), .DEB_CYCLES(DEB)) u_rise (
        .clk50m(clk50m), .rst(rst), .addr(addr), .re(re), .pins_i(pins_i),
        .data_out(dout[0]), .hit(hit_v[0]), .irq(irq_v[0]));
    mem_in_slice #(.AW(AW), .DW(DW), .ADDRESS(BASE), .EDGE_MODE(EDGE_FALL), .DEB_CYCLES(DEB)) u_fall (
        .clk50m(clk50m), .rst(rst), .addr(addr), .re(re), .pins_i(pins_i),
        .data_out(dout[1]), .hit(hit_v[1]), .irq(irq_v[1]));
    mem_in_slice #(.AW(AW), .DW(DW), .ADDRESS(BASE), .EDGE_MODE(EDGE_BOTH), .DEB_CYCLES(DEB)) u_both (
        .clk50m(clk50m), .rst(rst), .addr(addr), .re(re), .pins_i(pins_i),
        .data_out(dout[2]), .hit(hit_v[2]), .irq(irq_v[2]));

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
        end
    endtask

    // Compare every instance's ports against the model for the current inputs
    task automatic check_model();
        logic [15:0] exp_d;
        logic        exp_h;
        for (int k = 0; k < 3; k++) begin
            exp_h = (addr == BASE) || (addr == EDGE_A);
            exp_d = (addr == BASE) ? m_lvl : (addr == EDGE_A) ? m_edg[k] : 16'h0000;
            check_eq($sformatf("model_data_out[%0d]", k), dout[k], exp_d);
            check_eq($sformatf("model_hit[%0d]", k), {15'b0, hit_v[k]}, {15'b0, exp_h});
            check_eq($sformatf("model_irq[%0d]", k), {15'b0, irq_v[k]}, {15'b0, m_irq[k]});
        end
    endtask

    // Advance the model by one clock using the inputs present at the edge
    task automatic model_step();
        logic [15:0] nl, chg, sel;
        logic        clr;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_irq = '0;
            for (int k = 0; k < 3; k++) m_edg[k] = '0;
            for (int i = 0; i < 16; i++) m_run[i] = 0;
        end else begin
            nl  = m_lvl;
            chg = '0;
            for (int i = 0; i < 16; i++) begin
                if (m_s2[i] != m_lvl[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] >= DEB_M) begin
                        nl[i]    = m_s2[i];
                        chg[i]   = 1'b1;
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            clr = re && (addr == EDGE_A);
            for (int k = 0; k < 3; k++) begin
                sel = (k == 0) ? (chg & nl) : (k == 1) ? (chg & ~nl) : chg;
                m_edg[k] = (clr ? 16'h0000 : m_edg[k]) | sel;
                m_irq[k] = |m_edg[k];
            end
            m_lvl = nl;
            m_s2  = m_s1;
            m_s1  = pins_i;
        end
    endtask

    task automatic drive(input logic [15:0] p, input logic [14:0] a, input logic r, input logic rs);
        pins_i = p; addr = a; re = r; rst = rs;
        #1;
        check_model();
    endtask

    task automatic tick();
        @(posedge clk50m);
        model_step();
        @(negedge clk50m);
    endtask

    task automatic run(input logic [15:0] p, input logic [14:0] a, input logic r, input logic rs, input int n);
        for (int j = 0; j < n; j++) begin
            drive(p, a, r, rs);
            tick();
        end
    endtask

    initial begin
        logic [15:0] rp;
        logic [14:0] ra;
        m_s1 = 'x; m_s2 = 'x; m_lvl = 'x; m_irq = 'x;
        for (int k = 0; k < 3; k++) m_edg[k] = 'x;
        for (int i = 0; i < 16; i++) m_run[i] = 0;
        pins_i = 16'hFFFF; addr = BASE; re = 1'b0; rst = 1'b1;

        // Reset with all pins high: registers stay cleared
        for (int j = 0; j < 3; j++) begin
            @(posedge clk50m);
            model_step();
            @(negedge clk50m);
        end
        check_eq("reset_level", dout[0], 16'h0000);
        check_eq("reset_irq", {13'b0, irq_v}, 16'h0000);
        drive(16'hFFFF, EDGE_A, 1'b0, 1'b1);
        check_eq("reset_edge", dout[0], 16'h0000);
        run(16'h0000, BASE, 1'b0, 1'b1, 3);

        // Latency: level and irq appear exactly DL edges after the change
        drive(16'h0001, BASE, 1'b0, 1'b0);
        for (int n = 1; n <= DL + 1; n++) begin
            tick();
            check_eq($sformatf("latency_level_e%0d", n), dout[0], (n >= DL) ? 16'h0001 : 16'h0000);
            check_eq($sformatf("latency_irq_e%0d", n), {15'b0, irq_v[0]}, (n >= DL) ? 16'h0001 : 16'h0000);
        end

        // Glitch shorter than the debounce window is rejected
        run(16'h0001, EDGE_A, 1'b1, 1'b0, 1);
        if (DEB_M > 1) begin
            run(16'h0009, BASE, 1'b0, 1'b0, DEB_M - 1);
            run(16'h0001, BASE, 1'b0, 1'b0, DL + 2);
            check_eq("glitch_level", dout[0], 16'h0001);
            drive(16'h0001, EDGE_A, 1'b0, 1'b0);
            check_eq("glitch_edge", dout[0], 16'h0000);
        end
        // Pulse of exactly the window length is accepted, then released
        run(16'h0009, BASE, 1'b0, 1'b0, DEB_M);
        run(16'h0001, BASE, 1'b0, 1'b0, DL + DEB_M + 2);
        drive(16'h0001, EDGE_A, 1'b0, 1'b0);
        check_eq("pulse_edge_rise", dout[0], 16'h0008);
        check_eq("pulse_edge_fall", dout[1], 16'h0008);
        check_eq("pulse_edge_both", dout[2], 16'h0008);

        // Read-to-clear
        run(16'h0000, BASE, 1'b0, 1'b0, DL + 1);
        run(16'h0000, EDGE_A, 1'b1, 1'b0, 1);
        run(16'h0005, BASE, 1'b0, 1'b0, DL + 1);
        drive(16'h0005, EDGE_A, 1'b0, 1'b0);
        check_eq("rtc_value", dout[0], 16'h0005);
        check_eq("fall_ignores_rise", dout[1], 16'h0000);
        tick();
        drive(16'h0005, EDGE_A, 1'b0, 1'b0);
        check_eq("no_clear_without_re", dout[0], 16'h0005);
        check_eq("irq_held", {15'b0, irq_v[0]}, 16'h0001);
        drive(16'h0005, EDGE_A, 1'b1, 1'b0);
        check_eq("clear_read_value", dout[0], 16'h0005);
        tick();
        check_eq("cleared_edge", dout[0], 16'h0000);
        check_eq("cleared_irq", {15'b0, irq_v[0]}, 16'h0000);
        drive(16'h0005, BASE, 1'b0, 1'b0);

        // New edge in the same cycle as a clearing read survives
        run(16'h0000, BASE, 1'b0, 1'b0, DL + 1);
        run(16'h0000, EDGE_A, 1'b1, 1'b0, 1);
        run(16'h0001, BASE, 1'b0, 1'b0, DL + 1);
        run(16'h0005, BASE, 1'b0, 1'b0, DL - 1);
        drive(16'h0005, EDGE_A, 1'b1, 1'b0);
        check_eq("simul_read", dout[0], 16'h0001);
        tick();
        check_eq("simul_after", dout[0], 16'h0004);
        check_eq("simul_irq", {15'b0, irq_v[0]}, 16'h0001);

        // Decode miss
        drive(16'h0005, NONE_A, 1'b1, 1'b0);
        check_eq("miss_hit", {13'b0, hit_v}, 16'h0000);
        check_eq("miss_data", dout[0], 16'h0000);
        tick();

        // Randomized traffic against the model
        rp = 16'h0005;
        for (int n = 0; n < 600; n++) begin
            rp = rp ^ (16'($urandom) & 16'($urandom) & 16'($urandom) & 16'($urandom));
            case ($urandom_range(0, 3))
                0:       ra = BASE;
                1:       ra = EDGE_A;
                2:       ra = NONE_A;
                default: ra = 15'($urandom);
            endcase
            run(rp, ra, 1'($urandom), ($urandom_range(0, 63) == 0), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mem_in_slice
